// File: rtl/segway_pkg.sv
// Shared types and constants for the segway balance front end.
// Holds the integrator state encoding and the rate saturation helper.
package segway_pkg;

   typedef enum logic [0:0] {
      CAL = 1'b0,
      RUN = 1'b1
   } inert_state_t;

   localparam int ACC_SCALE  = 327;
   localparam int ACC_SHIFT  = 13;
   localparam int PTCH_INT_W = 27;

   function automatic logic [15:0] sat16(input logic signed [16:0] d);
      logic [15:0] r;
      if (d > 17'sd32767)
         r = 16'h7FFF;
      else if (d < -17'sd32768)
         r = 16'h8000;
      else
         r = d[15:0];
      return r;
   endfunction

endpackage

// File: rtl/inertial_integrator_gyro_cal.sv
// Gyro offset calibration: averages 2^LOG2N raw rate samples.
// Flags the completing sample so the top can move to RUN.
module gyro_cal
   import segway_pkg::*;
#(
   parameter int LOG2N = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_cal_en,
   input  logic        i_vld,
   input  logic        i_clr,
   input  logic [15:0] i_ptch_rt_raw,
   output logic [15:0] o_offset,
   output logic        o_cal_hit
);

   localparam int CW = LOG2N + 1;
   localparam logic [CW-1:0] LAST = CW'((2 ** LOG2N) - 1);

   logic [CW-1:0]      r_cnt;
   logic signed [23:0] r_acc;
   logic [15:0]        r_offset;

   logic               w_take;
   logic signed [23:0] w_sample;
   logic signed [23:0] w_sum;
   logic signed [23:0] w_avg;

   assign w_take    = i_cal_en & i_vld & ~i_clr;
   assign w_sample  = $signed({{8{i_ptch_rt_raw[15]}}, i_ptch_rt_raw});
   assign w_sum     = r_acc + w_sample;
   assign w_avg     = w_sum >>> LOG2N;
   assign o_cal_hit = w_take && (r_cnt == LAST);
   assign o_offset  = r_offset;

   // Offset is only rewritten on completion; a restart keeps the old one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt    <= '0;
         r_acc    <= '0;
         r_offset <= '0;
      end else if (i_clr || o_cal_hit) begin
         r_cnt <= '0;
         r_acc <= '0;
         if (o_cal_hit)
            r_offset <= w_avg[15:0];
      end else if (w_take) begin
         r_cnt <= r_cnt + 1'b1;
         r_acc <= w_sum;
      end
   end

endmodule

// File: rtl/inertial_integrator.sv
// Pitch complementary filter: gyro integration plus accel fusion nudge.
// Two-stage pipeline behind a gyro offset calibration phase.
module inertial_integrator
   import segway_pkg::*;
#(
   parameter bit                 fast_sim  = 1'b1,
   parameter int                 CAL_LOG2  = 8,
   parameter int                 FUSION    = 1024,
   parameter logic signed [15:0] AZ_OFFSET = 16'sh00A0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        vld,
   input  logic [15:0] ptch_rt_raw,
   input  logic [15:0] AZ,
   input  logic        cal_req,
   output logic [15:0] ptch,
   output logic [15:0] ptch_rt,
   output logic        ptch_vld,
   output logic        cal_done
);

   localparam int LOG2N = fast_sim ? 4 : CAL_LOG2;
   localparam logic signed [PTCH_INT_W-1:0] FUS = PTCH_INT_W'(FUSION);
   localparam logic signed [16:0] AZ_OFF17 = {AZ_OFFSET[15], AZ_OFFSET};

   inert_state_t r_state;

   logic                         r_s1_vld;
   logic [15:0]                  r_rt_comp;
   logic [15:0]                  r_acc_ptch;
   logic signed [PTCH_INT_W-1:0] r_ptch_int;
   logic [15:0]                  r_ptch_rt;
   logic                         r_ptch_vld;

   logic                         w_run;
   logic                         w_cal_en;
   logic                         w_take;
   logic                         w_cal_hit;
   logic [15:0]                  w_offset;
   logic signed [16:0]           w_rt_diff;
   logic signed [16:0]           w_az_diff;
   logic signed [25:0]           w_prod;
   logic signed [25:0]           w_acc_sh;
   logic [15:0]                  w_ptch;
   logic signed [PTCH_INT_W-1:0] w_rt_ext;
   logic signed [PTCH_INT_W-1:0] w_fuse;
   logic signed [PTCH_INT_W-1:0] w_int_nxt;

   assign w_run    = (r_state == RUN);
   assign w_cal_en = (r_state == CAL);
   assign w_take   = w_run & vld & ~cal_req;

   gyro_cal #(
      .LOG2N(LOG2N)
   ) u_gyro_cal (
      .clk          (clk),
      .rst          (rst),
      .i_cal_en     (w_cal_en),
      .i_vld        (vld),
      .i_clr        (cal_req),
      .i_ptch_rt_raw(ptch_rt_raw),
      .o_offset     (w_offset),
      .o_cal_hit    (w_cal_hit)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_state <= CAL;
      else if (cal_req)
         r_state <= CAL;
      else if (w_cal_hit)
         r_state <= RUN;
   end

   assign w_rt_diff = $signed({ptch_rt_raw[15], ptch_rt_raw})
                    - $signed({w_offset[15], w_offset});
   assign w_az_diff = $signed({AZ[15], AZ}) - AZ_OFF17;
   assign w_prod    = w_az_diff * $signed(26'(ACC_SCALE));
   assign w_acc_sh  = w_prod >>> ACC_SHIFT;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_vld   <= 1'b0;
         r_rt_comp  <= '0;
         r_acc_ptch <= '0;
      end else begin
         r_s1_vld <= w_take;
         if (w_take) begin
            r_rt_comp  <= sat16(w_rt_diff);
            r_acc_ptch <= w_acc_sh[15:0];
         end
      end
   end

   assign w_ptch   = r_ptch_int[PTCH_INT_W-1:PTCH_INT_W-16];
   assign w_rt_ext = $signed({{(PTCH_INT_W-16){r_rt_comp[15]}}, r_rt_comp});
   // Fusion pulls the integrator toward the accel estimate by a fixed step.
   assign w_fuse   = ($signed(r_acc_ptch) > $signed(w_ptch)) ? FUS : -FUS;
   assign w_int_nxt = r_ptch_int - w_rt_ext + w_fuse;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ptch_int <= '0;
         r_ptch_rt  <= '0;
         r_ptch_vld <= 1'b0;
      end else if (cal_req) begin
         r_ptch_int <= '0;
         r_ptch_rt  <= '0;
         r_ptch_vld <= 1'b0;
      end else begin
         r_ptch_vld <= r_s1_vld;
         if (r_s1_vld) begin
            r_ptch_int <= w_int_nxt;
            r_ptch_rt  <= r_rt_comp;
         end
      end
   end

   assign ptch     = w_ptch;
   assign ptch_rt  = r_ptch_rt;
   assign ptch_vld = r_ptch_vld;
   assign cal_done = w_run;

endmodule

// File: tb/tb_inertial_integrator.sv
// Directed bench for inertial_integrator with a small pitch model.
// Table vectors for single-sample updates plus multi-cycle sequences.
module tb_inertial_integrator;

   logic        clk;
   logic        rst;
   logic        vld;
   logic [15:0] ptch_rt_raw;
   logic [15:0] AZ;
   logic        cal_req;
   logic [15:0] ptch;
   logic [15:0] ptch_rt;
   logic        ptch_vld;
   logic        cal_done;

   int checks;
   int fails;
   logic signed [26:0] m_int;

   localparam int AZO = 160;

   typedef struct {
      int raw;
      int az;
      int exp_rt;
   } vec_t;

   vec_t tbl[5];

   inertial_integrator dut (
      .clk        (clk),
      .rst        (rst),
      .vld        (vld),
      .ptch_rt_raw(ptch_rt_raw),
      .AZ         (AZ),
      .cal_req    (cal_req),
      .ptch       (ptch),
      .ptch_rt    (ptch_rt),
      .ptch_vld   (ptch_vld),
      .cal_done   (cal_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   function automatic int sptch();
      return int'($signed(ptch));
   endfunction

   function automatic int m_ptch();
      logic [15:0] t;
      t = m_int[26:11];
      return int'($signed(t));
   endfunction

   function automatic int accp(input int az);
      int d;
      d = az - AZO;
      return (d * 327) >>> 13;
   endfunction

   task automatic cal(input int r, input int n);
      for (int i = 0; i < n; i++) begin
         vld = 1'b1;
         ptch_rt_raw = 16'(r);
         tick();
         chk("cal_no_strobe", int'(ptch_vld), 0);
         chk("cal_done", int'(cal_done), (i == n - 1) ? 1 : 0);
      end
      vld = 1'b0;
   endtask

   task automatic run_one(input int r, input int a, input int exp_rt);
      int f;
      vld = 1'b1;
      ptch_rt_raw = 16'(r);
      AZ = 16'(a);
      tick();
      vld = 1'b0;
      chk("lat_edge_n", int'(ptch_vld), 0);
      f = (accp(a) > m_ptch()) ? 1024 : -1024;
      m_int = m_int - 27'(exp_rt) + 27'(f);
      tick();
      chk("lat_strobe", int'(ptch_vld), 1);
      chk("ptch_rt", int'($signed(ptch_rt)), exp_rt);
      chk("ptch", sptch(), m_ptch());
      tick();
      chk("lat_post", int'(ptch_vld), 0);
   endtask

   initial begin
      int prev;
      int strobes;
      checks = 0;
      fails = 0;
      m_int = '0;
      tbl[0] = '{raw: 100,    az: AZO,        exp_rt: 0};
      tbl[1] = '{raw: 200,    az: AZO + 4096, exp_rt: 100};
      tbl[2] = '{raw: -32768, az: AZO,        exp_rt: -32768};
      tbl[3] = '{raw: 32767,  az: AZO - 4096, exp_rt: 32667};
      tbl[4] = '{raw: 0,      az: AZO + 16,   exp_rt: -100};

      rst = 1'b1;
      vld = 1'b0;
      cal_req = 1'b0;
      ptch_rt_raw = '0;
      AZ = 16'(AZO);
      tick();
      tick();
      chk("rst_ptch", sptch(), 0);
      chk("rst_ptch_rt", int'(ptch_rt), 0);
      chk("rst_ptch_vld", int'(ptch_vld), 0);
      chk("rst_cal_done", int'(cal_done), 0);
      rst = 1'b0;

      cal(100, 16);
      for (int i = 0; i < 5; i++)
         run_one(tbl[i].raw, tbl[i].az, tbl[i].exp_rt);

      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("async_rst_ptch", sptch(), 0);
      chk("async_rst_ptch_rt", int'(ptch_rt), 0);
      chk("async_rst_vld", int'(ptch_vld), 0);
      chk("async_rst_cal_done", int'(cal_done), 0);
      ptch_rt_raw = 16'(1234);
      for (int i = 0; i < 4; i++) begin
         vld = ~vld;
         tick();
         chk("rst_hold_vld", int'(ptch_vld), 0);
         chk("rst_hold_ptch", sptch(), 0);
         chk("rst_hold_cal_done", int'(cal_done), 0);
      end
      vld = 1'b0;
      rst = 1'b0;
      m_int = '0;

      cal(-100, 16);
      run_one(32767, AZO, 32767);

      cal_req = 1'b1;
      vld = 1'b1;
      ptch_rt_raw = 16'(1000);
      tick();
      cal_req = 1'b0;
      vld = 1'b0;
      chk("recal_cal_done", int'(cal_done), 0);
      chk("recal_ptch", sptch(), 0);
      chk("recal_ptch_rt", int'(ptch_rt), 0);
      chk("recal_vld", int'(ptch_vld), 0);
      m_int = '0;
      cal(50, 16);
      run_one(50, AZO, 0);

      cal_req = 1'b1;
      tick();
      cal_req = 1'b0;
      m_int = '0;
      ptch_rt_raw = 16'(500);
      vld = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      cal_req = 1'b1;
      tick();
      cal_req = 1'b0;
      vld = 1'b0;
      chk("restart_cal_done", int'(cal_done), 0);
      cal(0, 16);

      prev = -40000;
      strobes = 0;
      ptch_rt_raw = 16'(-2048);
      AZ = 16'(AZO);
      for (int k = 1; k <= 65; k++) begin
         vld = (k <= 64);
         tick();
         chk("b2b_strobe", int'(ptch_vld), (k >= 2) ? 1 : 0);
         if (ptch_vld) begin
            strobes++;
            chk("ptch_mono", int'(sptch() >= prev), 1);
            prev = sptch();
         end
      end
      vld = 1'b0;
      chk("b2b_count", strobes, 64);
      chk("fuse_ptch", sptch(), 32);
      tick();
      chk("b2b_tail", int'(ptch_vld), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule

// File: doc/inertial_integrator.md
Name: inertial_integrator

Overview:
- Upstream neighbour of the balance PID loop. Turns raw gyro pitch-rate and Z-accel samples into the `ptch`, `ptch_rt` and `ptch_vld` signals the PID consumes.
- After reset it calibrates the gyro offset, then runs a complementary filter: gyro integration plus an accelerometer-derived fusion nudge.
- Two-stage pipeline accepting one sample per clock.

Parameters:
- fast_sim, 1: when 1, calibration averages 2^4 samples; when 0, it averages 2^CAL_LOG2 samples.
- CAL_LOG2, 8: log2 of the calibration sample count when fast_sim=0.
- FUSION, 1024: magnitude of the per-sample fusion correction added to the integrator.
- AZ_OFFSET, 16'sh00A0: accelerometer zero offset subtracted from `AZ`.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- vld  in  1  new raw sample present this cycle.
- ptch_rt_raw  in  16  signed raw gyro pitch rate.
- AZ  in  16  signed raw Z acceleration.
- cal_req  in  1  one-cycle request to recalibrate.
- ptch  out  16  signed fused pitch; equals ptch_int[26:11].
- ptch_rt  out  16  signed offset-corrected pitch rate.
- ptch_vld  out  1  one-cycle strobe: `ptch` and `ptch_rt` are new.
- cal_done  out  1  high while in RUN.

Behaviour:
- Reset: the design has one clock (`clk`); reset `rst` is asynchronous and active-high.
  - All state clears: state=CAL, cnt=0, acc=0, offset=0, ptch_int=0, pipeline valids=0.
  - Outputs: ptch=0, ptch_rt=0, ptch_vld=0, cal_done=0.
  - Asserting `rst` mid-operation aborts immediately, with no partial update.
- State machine (2 states):
  - CAL:
    - Each `vld` adds sign-extended `ptch_rt_raw` into a 24-bit signed acc and increments cnt.
    - On the vld that makes cnt = N (N = 16 or 2^CAL_LOG2): offset <= (acc + sample) >>> log2N (arithmetic, truncated to 16 bits); acc and cnt clear; state goes to RUN.
    - `cal_done` rises on the following cycle.
    - `ptch_vld` stays 0 throughout CAL; `ptch` and `ptch_rt` hold 0.
  - RUN: the pipeline operates on every `vld`.
  - cal_req in RUN, next edge:
    - State goes to CAL; cal_done=0; ptch_int=0; ptch=0; ptch_rt=0; pipeline valids cleared.
    - The old offset is kept until the new calibration completes.
    - A `vld` in the same cycle as cal_req is discarded, not counted.
  - cal_req in CAL restarts calibration: cnt=0, acc=0; a coincident vld is discarded.
- Pipeline in RUN (vld sampled at edge N):
  - Stage 1, edge N:
    - rt_comp <= sat16(ptch_rt_raw − offset), where sat16 clamps a 17-bit difference to [−32768, 32767].
    - acc_ptch <= ((AZ − AZ_OFFSET) * 327) >>> 13, with a 17-bit difference and 26-bit product, sign-extended to 16 bits.
  - Stage 2, edge N+1:
    - ptch_int (27-bit signed) <= ptch_int − rt_comp + f, with f = +FUSION if acc_ptch > ptch (signed compare against current `ptch`), else −FUSION.
    - ptch_rt <= rt_comp.
    - ptch_vld <= 1 for exactly one cycle.
  - Latency: `vld` at edge N gives ptch_vld high in the cycle after edge N+1, i.e. 2 clocks.
  - Back-to-back vld every cycle is supported; each update uses the `ptch` written by the previous update.
- No wrap guard on ptch_int: 27 bits covers the physical range. It wraps two's-complement, and the bench must not rely on wrap.

Decomposition:
- Shared package `segway_pkg`:
  - typedef `inert_state_t` {CAL, RUN}.
  - Constants ACC_SCALE=327, ACC_SHIFT=13, PTCH_INT_W=27.
  - Function sat16.
- Optional sub-module `gyro_cal`: the CAL accumulator, counter and offset register. Outputs `offset` and `cal_done`.
- Filter, pipeline and FSM transitions stay in the top module.

Test Plan:
- Reset: assert rst mid-run → same cycle ptch=0, ptch_rt=0, ptch_vld=0, cal_done=0. Hold rst high with vld toggling → no output change.
- Calibration, fast_sim=1: 16 vlds with ptch_rt_raw=100 → cal_done=1 one cycle after the 16th, no ptch_vld during CAL. Then ptch_rt_raw=100 → ptch_rt=0.
- Latency: single vld at edge N in RUN → ptch_vld high only in the cycle after edge N+1. Ten back-to-back vlds → ten consecutive ptch_vld strobes.
- Integration/fusion:
  - Setup: offset=0, AZ=AZ_OFFSET (acc_ptch=0), ptch_rt_raw=−2048, 64 samples.
  - First update: acc_ptch=0 is not > ptch=0, so f=−FUSION.
  - Expected: ptch_int +1024 per sample, giving ptch=32 at the 64th strobe. Check ptch is non-decreasing across all 64 strobes.
- Saturation: offset=100, ptch_rt_raw=−32768 → ptch_rt=−32768. offset=−100, ptch_rt_raw=32767 → ptch_rt=32767.
- Recalibration: cal_req together with vld in RUN → next cycle cal_done=0, ptch=0, that sample uncounted. 16 further vlds at 50 → offset=50, cal_done=1.
